// File: rtl/pe_pkg.sv
// Shared definitions for the output-stationary systolic PE: default widths,
// FSM state encoding and saturation limits.
package pe_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_ACCUM_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } pe_state_e;

  // Limits are returned in 64 bits; callers keep the low w bits (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/systolic_pe_os_if.sv
// Per-PE bundle: west/north operand streams, their east/south pass-through,
// the column result chain with its drain strobes, and status flags.
interface systolic_pe_os_if
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH
) ();

  // Valids are presence flags with no backpressure: a pair is consumed on the
  // edge where a_valid_in and b_valid_in are both high; a lone valid only
  // travels through the pass-through registers.
  logic [DATA_WIDTH-1:0]   a_in;
  logic                    a_valid_in;
  logic                    a_last_in;
  logic [WEIGHT_WIDTH-1:0] b_in;
  logic                    b_valid_in;
  logic [DATA_WIDTH-1:0]   a_out;
  logic                    a_valid_out;
  logic                    a_last_out;
  logic [WEIGHT_WIDTH-1:0] b_out;
  logic                    b_valid_out;
  logic                    drain_load;
  logic                    drain_shift;
  logic [ACCUM_WIDTH-1:0]  res_in;
  logic                    res_valid_in;
  logic                    res_ovf_in;
  logic [ACCUM_WIDTH-1:0]  res_out;
  logic                    res_valid_out;
  logic                    res_ovf_out;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output a_in, a_valid_in, a_last_in, b_in, b_valid_in,
    output drain_load, drain_shift, res_in, res_valid_in, res_ovf_in,
    input  a_out, a_valid_out, a_last_out, b_out, b_valid_out,
    input  res_out, res_valid_out, res_ovf_out, busy, done, err
  );

  modport slave (
    input  a_in, a_valid_in, a_last_in, b_in, b_valid_in,
    input  drain_load, drain_shift, res_in, res_valid_in, res_ovf_in,
    output a_out, a_valid_out, a_last_out, b_out, b_valid_out,
    output res_out, res_valid_out, res_ovf_out, busy, done, err
  );

endinterface

// File: rtl/sat_mac.sv
// Combinational signed multiply-accumulate with one guard bit, overflow
// detection and clamp-or-wrap result selection.
module sat_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
  parameter bit SATURATE     = 1'b1
) (
  input  logic [ACCUM_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [WEIGHT_WIDTH-1:0] b,
  input  logic                    clear_first,
  output logic [ACCUM_WIDTH-1:0]  next_acc,
  output logic                    ovf
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic [63:0] MAX64 = sat_max(ACCUM_WIDTH);
  localparam logic [63:0] MIN64 = sat_min(ACCUM_WIDTH);

  logic signed [PW-1:0]        a_x;
  logic signed [PW-1:0]        b_x;
  logic signed [PW-1:0]        prod;
  logic        [ACCUM_WIDTH:0] prod_x;
  logic        [ACCUM_WIDTH:0] acc_x;
  logic        [ACCUM_WIDTH:0] sum;

  // Operands widened to the product width first so the multiply is exact.
  assign a_x    = {{WEIGHT_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_x    = {{DATA_WIDTH{b[WEIGHT_WIDTH-1]}}, b};
  assign prod   = a_x * b_x;
  assign prod_x = {{(ACCUM_WIDTH + 1 - PW){prod[PW-1]}}, prod};
  assign acc_x  = clear_first ? '0 : {acc[ACCUM_WIDTH-1], acc};
  assign sum    = acc_x + prod_x;
  assign ovf    = sum[ACCUM_WIDTH] ^ sum[ACCUM_WIDTH-1];

  always_comb begin
    next_acc = sum[ACCUM_WIDTH-1:0];
    if (SATURATE && ovf) begin
      next_acc = sum[ACCUM_WIDTH] ? MIN64[ACCUM_WIDTH-1:0] : MAX64[ACCUM_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/systolic_pe_os.sv
// Output-stationary PE: registered operand pass-through, tile accumulator FSM
// and a double-buffered result register on the column shift chain.
module systolic_pe_os
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
  parameter bit SATURATE     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  systolic_pe_os_if.slave   pe,
  output pe_state_e         dbg_state
);

  pe_state_e              state;
  logic [ACCUM_WIDTH-1:0] acc;
  logic                   ovf;
  logic [ACCUM_WIDTH-1:0] mac_acc;
  logic                   mac_ovf;
  logic                   fire;
  logic                   clear_first;

  assign fire        = pe.a_valid_in & pe.b_valid_in;
  assign clear_first = (state != ST_ACCUM);
  assign dbg_state   = state;

  sat_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ACCUM_WIDTH (ACCUM_WIDTH),
    .SATURATE    (SATURATE)
  ) u_mac (
    .acc        (acc),
    .a          (pe.a_in),
    .b          (pe.b_in),
    .clear_first(clear_first),
    .next_acc   (mac_acc),
    .ovf        (mac_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe.a_out       <= '0;
      pe.a_valid_out <= 1'b0;
      pe.a_last_out  <= 1'b0;
      pe.b_out       <= '0;
      pe.b_valid_out <= 1'b0;
    end else begin
      pe.a_out       <= pe.a_in;
      pe.a_valid_out <= pe.a_valid_in;
      pe.a_last_out  <= pe.a_last_in;
      pe.b_out       <= pe.b_in;
      pe.b_valid_out <= pe.b_valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      acc               <= '0;
      ovf               <= 1'b0;
      pe.busy           <= 1'b0;
      pe.done           <= 1'b0;
      pe.err            <= 1'b0;
      pe.res_out        <= '0;
      pe.res_valid_out  <= 1'b0;
      pe.res_ovf_out    <= 1'b0;
    end else begin
      // Load samples the accumulator before this edge's tile update.
      if (pe.drain_load) begin
        if (state == ST_HOLD) begin
          pe.res_out       <= acc;
          pe.res_valid_out <= 1'b1;
          pe.res_ovf_out   <= ovf;
        end else begin
          pe.res_valid_out <= 1'b0;
          pe.res_ovf_out   <= 1'b0;
        end
      end else if (pe.drain_shift) begin
        pe.res_out       <= pe.res_in;
        pe.res_valid_out <= pe.res_valid_in;
        pe.res_ovf_out   <= pe.res_ovf_in;
      end

      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (fire) begin
            acc <= mac_acc;
            ovf <= clear_first ? mac_ovf : (ovf | mac_ovf);
            if (pe.a_last_in) begin
              state   <= ST_HOLD;
              pe.busy <= 1'b0;
              pe.done <= 1'b1;
            end else begin
              state   <= ST_ACCUM;
              pe.busy <= 1'b1;
              pe.done <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (pe.drain_load) begin
            pe.err <= 1'b0;
            if (fire) begin
              acc <= mac_acc;
              ovf <= mac_ovf;
              if (pe.a_last_in) begin
                state   <= ST_HOLD;
                pe.busy <= 1'b0;
                pe.done <= 1'b1;
              end else begin
                state   <= ST_ACCUM;
                pe.busy <= 1'b1;
                pe.done <= 1'b0;
              end
            end else begin
              state   <= ST_IDLE;
              pe.busy <= 1'b0;
              pe.done <= 1'b0;
            end
          end else if (fire) begin
            pe.err <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          pe.busy <= 1'b0;
          pe.done <= 1'b0;
        end
      endcase
    end
  end

endmodule
